// File: rtl/operand_latch.sv
// Operand latch between register-file read and execute: captures both source
// operands with same-cycle write-back bypass and keeps them current while stalled.
module operand_latch #(
   parameter int DATA_W   = 16,
   parameter int REG_ID_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [REG_ID_W-1:0] src1_id,
   input  logic [REG_ID_W-1:0] src2_id,
   input  logic [DATA_W-1:0]   rf_data1,
   input  logic [DATA_W-1:0]   rf_data2,
   input  logic [REG_ID_W-1:0] dst_id,
   input  logic                dst_wen,
   input  logic                wb_wen,
   input  logic [REG_ID_W-1:0] wb_id,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_op1,
   output logic [DATA_W-1:0]   out_op2,
   output logic [REG_ID_W-1:0] out_src1_id,
   output logic [REG_ID_W-1:0] out_src2_id,
   output logic [REG_ID_W-1:0] out_dst_id,
   output logic                out_dst_wen
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                capture;
   logic                hit1, hit2;
   logic [DATA_W-1:0]   op1_cap, op2_cap;
   logic [DATA_W-1:0]   op1_q, op2_q;
   logic [REG_ID_W-1:0] src1_q, src2_q, dst_q;
   logic                dst_wen_q;

   // Handshake: a transfer happens on an edge where valid && ready are both high;
   // ready never depends on valid, and valid, once high, holds until the transfer
   // or a flush.
   assign in_ready = (state_q == ST_EMPTY) || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = ST_EMPTY;
      else if (capture)
         state_d = ST_FULL;
      else if (state_q == ST_FULL && out_ready)
         state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   // The register file writes on the same edge we capture, so its read port
   // is stale for a register being written this cycle.
   always_comb begin
      op1_cap = rf_data1;
      op2_cap = rf_data2;
      if (src1_id == '0)
         op1_cap = '0;
      else if (wb_wen && wb_id == src1_id)
         op1_cap = wb_data;
      if (src2_id == '0)
         op2_cap = '0;
      else if (wb_wen && wb_id == src2_id)
         op2_cap = wb_data;
   end

   assign hit1 = wb_wen && (wb_id == src1_q) && (src1_q != '0);
   assign hit2 = wb_wen && (wb_id == src2_q) && (src2_q != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op1_q     <= '0;
         op2_q     <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         dst_q     <= '0;
         dst_wen_q <= 1'b0;
      end else if (capture) begin
         op1_q     <= op1_cap;
         op2_q     <= op2_cap;
         src1_q    <= src1_id;
         src2_q    <= src2_id;
         dst_q     <= dst_id;
         dst_wen_q <= dst_wen;
      end else if (state_q == ST_FULL && !out_ready && !flush) begin
         if (hit1)
            op1_q <= wb_data;
         if (hit2)
            op2_q <= wb_data;
      end
   end

   assign out_valid   = (state_q == ST_FULL);
   assign out_op1     = op1_q;
   assign out_op2     = op2_q;
   assign out_src1_id = src1_q;
   assign out_src2_id = src2_q;
   assign out_dst_id  = dst_q;
   assign out_dst_wen = dst_wen_q && out_valid;

endmodule

// File: tb/tb_operand_latch.sv
// Directed bench for operand_latch: expected transfers go into a queue at issue
// time and a negedge monitor pops and compares them whenever execute accepts.
module tb_operand_latch;

   localparam int EXP_W = 45;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  src1_id, src2_id, dst_id, wb_id;
   logic [15:0] rf_data1, rf_data2, wb_data;
   logic        dst_wen, wb_wen, flush;
   logic        out_valid, out_ready;
   logic [15:0] out_op1, out_op2;
   logic [3:0]  out_src1_id, out_src2_id, out_dst_id;
   logic        out_dst_wen;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   operand_latch #(.DATA_W(16), .REG_ID_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .src1_id(src1_id), .src2_id(src2_id),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .dst_id(dst_id), .dst_wen(dst_wen),
      .wb_wen(wb_wen), .wb_id(wb_id), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2),
      .out_src1_id(out_src1_id), .out_src2_id(out_src2_id),
      .out_dst_id(out_dst_id), .out_dst_wen(out_dst_wen)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] pack(input logic [15:0] op1, input logic [15:0] op2,
                                              input logic [3:0] s1, input logic [3:0] s2,
                                              input logic [3:0] d, input logic dw);
      return {op1, op2, s1, s2, d, dw};
   endfunction

   // driver tasks
   task automatic drive(input logic iv, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [15:0] r1, input logic [15:0] r2,
                        input logic [3:0] d, input logic dw,
                        input logic ww, input logic [3:0] wi, input logic [15:0] wd,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      src1_id   = s1;
      src2_id   = s2;
      rf_data1  = r1;
      rf_data2  = r2;
      dst_id    = d;
      dst_wen   = dw;
      wb_wen    = ww;
      wb_id     = wi;
      wb_data   = wd;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, ordy, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: op1=0x%0h op2=0x%0h, expected no transfer",
                     out_op1, out_op2);
         end else begin
            e = exp_q.pop_front();
            check("sb_op1", 32'(out_op1), 32'(e[44:29]));
            check("sb_op2", 32'(out_op2), 32'(e[28:13]));
            check("sb_src1", 32'(out_src1_id), 32'(e[12:9]));
            check("sb_src2", 32'(out_src2_id), 32'(e[8:5]));
            check("sb_dst", 32'(out_dst_id), 32'(e[4:1]));
            check("sb_dst_wen", 32'(out_dst_wen), 32'(e[0]));
         end
      end
   end

   initial begin
      rst = 1'b0;
      idle(1'b0);
      #3;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_op1", 32'(out_op1), 0);
      check("rst_op2", 32'(out_op2), 0);
      check("rst_ids", 32'({out_src1_id, out_src2_id, out_dst_id}), 0);
      check("rst_dst_wen", 32'(out_dst_wen), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      step();

      // basic capture: r3=0x1234, r5=0xBEEF
      drive(1'b1, 4'd3, 4'd5, 16'h1234, 16'hBEEF, 4'd1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      exp_q.push_back(pack(16'h1234, 16'hBEEF, 4'd3, 4'd5, 4'd1, 1'b1));
      step();
      idle(1'b1);
      step();

      // same-cycle bypass on src1, src2 is r0
      drive(1'b1, 4'd7, 4'd0, 16'h0001, 16'h3333, 4'd2, 1'b0, 1'b1, 4'd7, 16'hA5A5, 1'b1, 1'b0);
      exp_q.push_back(pack(16'hA5A5, 16'h0000, 4'd7, 4'd0, 4'd2, 1'b0));
      step();
      // write-back to r0 must not reach src1=0
      drive(1'b1, 4'd0, 4'd4, 16'hFFFF, 16'h4444, 4'd0, 1'b0, 1'b1, 4'd0, 16'h5555, 1'b1, 1'b0);
      exp_q.push_back(pack(16'h0000, 16'h4444, 4'd0, 4'd4, 4'd0, 1'b0));
      step();
      // both sources the same register, both bypassed
      drive(1'b1, 4'd6, 4'd6, 16'h0101, 16'h0101, 4'd6, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 1'b0);
      exp_q.push_back(pack(16'h6666, 16'h6666, 4'd6, 4'd6, 4'd6, 1'b1));
      step();
      idle(1'b1);
      step();

      // stall refresh: src2=r9 refreshed while held
      drive(1'b1, 4'd2, 4'd9, 16'h2222, 16'h0010, 4'd9, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
      exp_q.push_back(pack(16'h2222, 16'h0F0F, 4'd2, 4'd9, 4'd9, 1'b1));
      step();
      idle(1'b0);
      @(negedge clk);
      check("stall1_in_ready", 32'(in_ready), 0);
      check("stall1_op2", 32'(out_op2), 32'h0010);
      step();
      drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, 4'd9, 16'h0F0F, 1'b0, 1'b0);
      @(negedge clk);
      check("stall2_in_ready", 32'(in_ready), 0);
      check("stall2_op2_registered", 32'(out_op2), 32'h0010);
      step();
      idle(1'b0);
      @(negedge clk);
      check("stall3_op2_refreshed", 32'(out_op2), 32'h0F0F);
      check("stall3_op1_kept", 32'(out_op1), 32'h2222);
      check("stall3_out_valid", 32'(out_valid), 1);
      check("stall3_in_ready", 32'(in_ready), 0);
      step();
      idle(1'b1);
      step();

      // back-to-back stream of four
      for (int i = 0; i < 4; i++) begin
         logic [3:0]  s1, s2;
         logic [15:0] v1, v2;
         s1 = 4'(i + 1);
         s2 = 4'(i + 10);
         v1 = 16'h1000 + 16'(i);
         v2 = 16'h2000 + 16'(i);
         drive(1'b1, s1, s2, v1, v2, 4'(i + 4), 1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
         exp_q.push_back(pack(v1, v2, s1, s2, 4'(i + 4), 1'b1));
         @(negedge clk);
         check("stream_in_ready", 32'(in_ready), 1);
         if (i > 0)
            check("stream_no_bubble", 32'(out_valid), 1);
         step();
      end
      idle(1'b1);
      @(negedge clk);
      check("stream_last_valid", 32'(out_valid), 1);
      step();
      @(negedge clk);
      check("stream_drained", 32'(out_valid), 0);
      step();

      // flush while full and stalled, new instruction present
      drive(1'b1, 4'd8, 4'd3, 16'h8888, 16'h3333, 4'd8, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'd1, 4'd2, 16'hDEAD, 16'hBEEF, 4'd5, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      step();
      idle(1'b1);
      @(negedge clk);
      check("flush_full_valid", 32'(out_valid), 0);
      check("flush_full_dst_wen", 32'(out_dst_wen), 0);
      step();
      @(negedge clk);
      check("flush_not_presented", 32'(out_valid), 0);
      // flush from empty with an instruction that would otherwise be taken
      drive(1'b1, 4'd4, 4'd5, 16'h4040, 16'h5050, 4'd3, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
      step();
      idle(1'b1);
      @(negedge clk);
      check("flush_empty_valid", 32'(out_valid), 0);
      step();

      // asynchronous reset while held
      drive(1'b1, 4'd3, 4'd4, 16'h3030, 16'h4040, 4'd7, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_ops", 32'({out_op1, out_op2}), 0);
      check("arst_ids", 32'({out_src1_id, out_src2_id, out_dst_id}), 0);
      check("arst_dst_wen", 32'(out_dst_wen), 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      drive(1'b1, 4'd11, 4'd12, 16'hB0B0, 16'hC0C0, 4'd13, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      exp_q.push_back(pack(16'hB0B0, 16'hC0C0, 4'd11, 4'd12, 4'd13, 1'b1));
      step();
      idle(1'b1);
      step();
      step();

      check("queue_drain", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_latch.md
# operand_latch

Pipeline stage directly downstream of the 16-entry register file: captures the two read-port values for the instruction in decode, repairs them with same-cycle write-back bypass, and presents them to execute. The register file writes on the clock edge and reads combinationally, so a read issued in the same cycle as a write to that register returns the old value. This block closes that gap and keeps held operands current while execute stalls. It also provides valid/ready flow control and a flush.

## Interface
- DATA_W, 16, operand/register width
- REG_ID_W, 4, register index width (16 registers; register 0 reads as zero)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- src1_id, src2_id  in  REG_ID_W  source register indices driven to the register file read decoders
- rf_data1, rf_data2  in  DATA_W  register file read-port values for src1_id/src2_id
- dst_id  in  REG_ID_W  destination register
- dst_wen  in  1  instruction writes dst_id
- wb_wen  in  1  write-back writing the register file this cycle
- wb_id  in  REG_ID_W  write-back register index
- wb_data  in  DATA_W  write-back data
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts this cycle
- out_op1, out_op2  out  DATA_W  resolved operands
- out_src1_id, out_src2_id  out  REG_ID_W  held source indices
- out_dst_id, out_dst_wen  out  REG_ID_W, 1  held destination

## Operation
- Single-entry pipeline register with two states. EMPTY means out_valid=0. FULL means out_valid=1.
- in_ready = !out_valid || out_ready. This signal is combinational, and no path through it depends on in_valid.
- The stage captures the incoming instruction when in_valid && in_ready && !flush. After capture the stage is FULL.
- When the stage is FULL and out_ready=1 with no capture, the stage goes to EMPTY.
- When the stage is FULL, out_ready=1, and a capture happens, the stage stays FULL with the new instruction (back-to-back, no bubble).
- Operand resolution at capture, for each source n:
  - If src_n_id==0, the operand is 0.
  - Otherwise, if wb_wen && wb_id==src_n_id, the operand is wb_data.
  - Otherwise the operand is rf_data_n.
- Refresh while held: when FULL and the held entry is not leaving (out_ready=0), for each source n:
  - If wb_wen && wb_id==out_src_n_id && out_src_n_id!=0, out_op_n is replaced with wb_data on the next edge.
  - Destination fields are never modified.
- If src1_id==src2_id, both operands receive the same bypass or refresh value.
- wb_wen with wb_id==0 never affects any operand.
- flush=1 clears out_valid at the next edge, regardless of in_valid, out_ready, or the current state. Data registers may keep stale values. The incoming instruction in that cycle is dropped.
- out_dst_wen is qualified: it is forced to 0 whenever out_valid=0.

## Timing
- Reset (rst=0, asynchronous) sets:
  - out_valid=0
  - out_op1=out_op2=0
  - out_src1_id=out_src2_id=out_dst_id=0
  - out_dst_wen=0
  - in_ready follows at 1 once reset releases.
- Latency is 1 cycle: a capture at edge N makes the operands visible on outputs after edge N. Throughput is 1 instruction per cycle while out_ready=1.
- The bypass compare uses same-cycle wb_* inputs. The register file write and the capture occur on the same edge.
- Priority at each edge:
  1. reset
  2. flush
  3. capture
  4. refresh of held entry
  5. hold
- Outputs are registered only; no combinational path from wb_* to out_op*.
- If reset asserts mid-stall, the held entry is lost. The first capture after release behaves as from EMPTY.

## Test plan
- Reset, then capture: with registers r3=0x1234 and r5=0xBEEF, issue src1=3, src2=5. Required: out_op1=0x1234 and out_op2=0xBEEF one cycle later, with out_valid=1.
- Same-cycle bypass: issue src1=7, with r7 holding 0x0001. In the same cycle drive wb_wen=1, wb_id=7, wb_data=0xA5A5. Required: out_op1=0xA5A5.
- Zero register: issue src1=0 with rf_data1=0xFFFF, and drive wb_wen=1, wb_id=0, wb_data=0x5555. Required: out_op1=0x0000.
- Stall refresh: capture src2=9 (value 0x0010), then hold out_ready=0 for 3 cycles. In cycle 2 write back wb_id=9, wb_data=0x0F0F. Required: out_op2=0x0F0F after that edge, out_valid stays 1, and in_ready=0 throughout.
- Back-to-back stream: 4 instructions with in_valid=1 and out_ready=1 every cycle. Required: 4 consecutive out_valid cycles in order, no bubble, and in_ready constantly 1.
- Flush and reset mid-operation:
  - flush=1 while FULL and out_ready=0, with a new in_valid present. Required: out_valid=0 next cycle and the new instruction is not presented.
  - rst=0 asynchronously while FULL. Required: all outputs are 0 immediately, without waiting for a clock edge.
